// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the multiplexed seven-segment driver:
// hex-to-segment table (active-low gfedcba), all-off patterns, digit count
// and the display payload struct latched by shadow/display registers.
// Optional blink support in seg7_scan is enabled by defining SEG7_BLINK_EN.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIG_W      = 2;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
    localparam int unsigned SEG_W      = 8;

    localparam logic [SEG_W-1:0]      SEG_OFF = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;

    // Index 15 is listed first so HEX_SEG[n] is the pattern for nibble n.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Everything captured by one load strobe.
    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [NUM_DIGITS-1:0] point;
        logic [NUM_DIGITS-1:0] blank;
        logic [NUM_DIGITS-1:0] blink;
    } disp_t;

    // One-hot (active-high) select for a digit index.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [DIG_W-1:0] dig);
        return NUM_DIGITS'(1) << dig;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational nibble to active-low segment decoder.
// Ports:
//   nibble_i  [3:0]  hex digit to show
//   dp_i             decimal point enable (1 = lit)
//   blank_i          1 = all segments off, dp included
//   seg_c_o   [7:0]  {dp, g..a}, active-low
// ---------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             dp_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_c_o
);

    logic [SEG_W-1:0] glyph_c;

    always_comb begin
        glyph_c = HEX_SEG[nibble_i];
        seg_c_o = SEG_OFF;
        if (!blank_i) begin
            seg_c_o = {~dp_i, glyph_c[6:0]};
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
// Drives a 4-digit common-anode multiplexed seven-segment display. Loads are
// captured into shadow registers and only copied to the display registers at
// a frame boundary, so a frame never shows a mix of old and new values.
// Optional blink (macro SEG7_BLINK_EN): a frame counter toggles a blink phase
// every BLINK_FRAMES frames; digits with their latched blink bit set are
// blanked while the phase is 1. Without the macro blink_mask has no effect.
// Parameters:
//   SCAN_DIV      cycles each digit stays lit (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   data  [15:0]  hex value, digit k = data[4k+3:4k]
//   point [3:0]   per-digit decimal point enable
//   blank [3:0]   per-digit blank
//   blink_mask[3:0] per-digit blink enable
//   load          capture strobe for the four inputs above
//   an    [3:0]   digit enables, active-low (registered)
//   seg   [7:0]   segments {dp,g..a}, active-low (registered)
//   updated       one-cycle pulse when a load becomes visible (registered)
// ---------------------------------------------------------------------------
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data,
    input  logic [NUM_DIGITS-1:0] point,
    input  logic [NUM_DIGITS-1:0] blank,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  load,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  updated
);

    localparam int unsigned    CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DIG_W-1:0]      dig_q,    dig_d;
    logic                  pend_q,   pend_d;
    disp_t                 shadow_q, shadow_d;
    disp_t                 disp_q,   disp_d;
    logic [NUM_DIGITS-1:0] an_q,     an_d;
    logic [SEG_W-1:0]      seg_q;
    logic                  upd_q,    upd_d;

    disp_t                 in_c;
    logic                  at_wrap_c;
    logic                  frame_end_c;
    logic                  phase_d;
    logic [NIB_W-1:0]      nib_c;
    logic                  dp_c;
    logic                  blank_c;
    logic [SEG_W-1:0]      seg_c;

    // Scan position: end of a digit slot, and end of the last digit's slot.
    assign at_wrap_c   = (cnt_q == CNT_LAST);
    assign frame_end_c = at_wrap_c && (dig_q == DIG_LAST);

    // Scan counters, shadow/pending handling and display update.
    always_comb begin
        in_c     = {data, point, blank, blink_mask};
        cnt_d    = at_wrap_c ? '0 : cnt_q + CNT_W'(1);
        dig_d    = at_wrap_c ? dig_q + DIG_W'(1) : dig_q;
        shadow_d = load ? in_c : shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        upd_d    = 1'b0;

        if (frame_end_c) begin
            // A load on the boundary itself bypasses the shadow copy.
            pend_d = 1'b0;
            if (load) begin
                disp_d = in_c;
                upd_d  = 1'b1;
            end else if (pend_q) begin
                disp_d = shadow_q;
                upd_d  = 1'b1;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end

        // Outputs follow next-state digit/display so an and seg move together.
        an_d    = ~digit_onehot(dig_d);
        nib_c   = NIB_W'(disp_d.data >> {dig_d, 2'b00});
        dp_c    = disp_d.point[dig_d];
        blank_c = disp_d.blank[dig_d] | (disp_d.blink[dig_d] & phase_d);
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned      FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_q, frm_d;
    logic             phase_q;

    // Frame counter toggles the blink phase every BLINK_FRAMES boundaries.
    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (frame_end_c) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end
`else
    logic [31:0] unused_blink_frames;

    assign phase_d             = 1'b0;
    assign unused_blink_frames = BLINK_FRAMES;
`endif

    seg7_hex_decode u_dec (
        .nibble_i (nib_c),
        .dp_i     (dp_c),
        .blank_i  (blank_c),
        .seg_c_o  (seg_c)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            dig_q    <= '0;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            disp_q   <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            upd_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            an_q     <= an_d;
            seg_q    <= seg_c;
            upd_q    <= upd_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign updated = upd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
// Self-checking bench for seg7_scan with SCAN_DIV = 4, BLINK_FRAMES = 2.
// Every cycle is compared against a reference built from absolute cycle
// arithmetic (digit = (t / SCAN_DIV) % 4, frame = t / (4*SCAN_DIV)); a
// vector table and hand sequences add fixed-value checks.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLINK_FRAMES = 2;
    localparam int          FRAME        = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic [3:0]  point = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink_mask = '0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        updated;

    seg7_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .point      (point),
        .blank      (blank),
        .blink_mask (blink_mask),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .updated    (updated)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state: edges since reset release, visible and pending values.
    int          e;
    logic [15:0] m_data,  s_data;
    logic [3:0]  m_point, s_point, m_blank, s_blank, m_blink, s_blink;
    bit          m_pend, m_upd;

    typedef struct packed {
        logic [15:0]     d;
        logic [3:0]      p;
        logic [3:0]      b;
        logic [3:0][7:0] exp;   // exp[k] = seg while digit k is lit
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    function automatic int blink_phase(input int ee);
`ifdef SEG7_BLINK_EN
        return ((ee / FRAME) / BLINK_FRAMES) % 2;
`else
        return 0;
`endif
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] oh;
        oh = 4'b0001 << ((e / SCAN_DIV) % 4);
        return ~oh;
    endfunction

    function automatic logic [7:0] exp_seg();
        int         d;
        logic [3:0] nib;
        logic [7:0] g;
        d   = (e / SCAN_DIV) % 4;
        nib = 4'(m_data >> (4 * d));
        g   = hex_tbl[nib];
        if (m_blank[d] || (m_blink[d] && blink_phase(e) == 1)) return 8'hFF;
        return {~m_point[d], g[6:0]};
    endfunction

    task automatic model_reset();
        e = 0;
        m_data = '0; m_point = '0; m_blank = '0; m_blink = '0;
        s_data = '0; s_point = '0; s_blank = '0; s_blink = '0;
        m_pend = 1'b0; m_upd = 1'b0;
    endtask

    // One clock: drive inputs, advance the reference, compare all outputs.
    task automatic tick(input bit ld, input logic [15:0] d, input logic [3:0] p,
                        input logic [3:0] b, input logic [3:0] bm);
        load = ld; data = d; point = p; blank = b; blink_mask = bm;
        @(posedge clk);
        e++;
        m_upd = 1'b0;
        if (e % FRAME == 0) begin
            if (ld) begin
                m_data = d; m_point = p; m_blank = b; m_blink = bm; m_upd = 1'b1;
            end else if (m_pend) begin
                m_data = s_data; m_point = s_point; m_blank = s_blank; m_blink = s_blink;
                m_upd = 1'b1;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            s_data = d; s_point = p; s_blank = b; s_blink = bm; m_pend = 1'b1;
        end
        #1;
        load = 1'b0;
        check("an", 32'(an), 32'(exp_an()));
        check("seg", 32'(seg), 32'(exp_seg()));
        check("updated", 32'(updated), 32'(m_upd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_until(input int phase, input int modulus);
        for (int i = 0; i < modulus && (e % modulus) != phase; i++) idle(1);
        check("align", 32'(e % modulus), 32'(phase));
    endtask

    // Asynchronous reset in the middle of a cycle, then release.
    task automatic apply_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_seg", 32'(seg), 32'h000000FF);
        check("rst_upd", 32'(updated), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int upd_cnt;
        int blank_cnt;
        bit is_blank;

        vecs[0] = '{16'h1A2F, 4'b0001, 4'b0000, {8'hF9, 8'h88, 8'hA4, 8'h0E}};
        vecs[1] = '{16'h3456, 4'b0000, 4'b0000, {8'hB0, 8'h99, 8'h92, 8'h82}};
        vecs[2] = '{16'h789B, 4'b1010, 4'b0000, {8'h78, 8'h80, 8'h10, 8'h83}};
        vecs[3] = '{16'hCDE0, 4'b0010, 4'b1001, {8'hFF, 8'hA1, 8'h06, 8'hFF}};

        model_reset();

        // Power-on reset state.
        #12;
        check("por_an", 32'(an), 32'h0000000F);
        check("por_seg", 32'(seg), 32'h000000FF);
        check("por_upd", 32'(updated), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // First edge and scan order.
        idle(1);
        check("first_an", 32'(an), 32'h0000000E);
        check("first_seg", 32'(seg), 32'h000000C0);
        idle(3);
        check("scan_an1", 32'(an), 32'h0000000D);
        idle(4);
        check("scan_an2", 32'(an), 32'h0000000B);
        idle(4);
        check("scan_an3", 32'(an), 32'h00000007);
        idle(3);
        check("scan_wrap", 32'(an), 32'h00000007);
        idle(1);
        check("scan_an0", 32'(an), 32'h0000000E);

        // Table: mid-frame load, visible only from the next boundary.
        for (int v = 0; v < 4; v++) begin
            idle_until(5, FRAME);
            tick(1'b1, vecs[v].d, vecs[v].p, vecs[v].b, 4'h0);
            idle_until(0, FRAME);
            check("tbl_upd", 32'(updated), 32'h1);
            for (int k = 0; k < 4; k++) begin
                check("tbl_seg", 32'(seg), 32'(vecs[v].exp[k]));
                idle(SCAN_DIV);
            end
        end

        // Two loads before one boundary: last wins, single pulse.
        idle_until(3, FRAME);
        tick(1'b1, 16'h1111, 4'h0, 4'h0, 4'h0);
        idle(2);
        tick(1'b1, 16'h2222, 4'h0, 4'h0, 4'h0);
        upd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            upd_cnt += int'(updated);
            if (e % FRAME == 2) check("two_load_seg", 32'(seg), 32'h000000A4);
        end
        check("two_load_pulses", 32'(upd_cnt), 32'h1);

        // Load exactly on the boundary cycle.
        idle_until(FRAME - 1, FRAME);
        tick(1'b1, 16'h5678, 4'h0, 4'b0100, 4'h0);
        check("bnd_upd", 32'(updated), 32'h1);
        check("bnd_seg0", 32'(seg), 32'h00000080);
        idle_until(2 * SCAN_DIV, FRAME);
        check("bnd_an2", 32'(an), 32'h0000000B);
        check("bnd_blank2", 32'(seg), 32'h000000FF);
        idle_until(0, FRAME);
        check("bnd_no_pend", 32'(updated), 32'h0);

        // Blink on digit 0, checked across 8 frames aligned to the phase cycle.
        idle_until(4, FRAME);
        tick(1'b1, 16'h0000, 4'h0, 4'h0, 4'b0001);
        idle_until(0, FRAME * 2 * BLINK_FRAMES);
        blank_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            is_blank = (seg == 8'hFF);
            blank_cnt += int'(is_blank);
`ifdef SEG7_BLINK_EN
            check("blink_frame", 32'(is_blank), 32'((f / BLINK_FRAMES) % 2));
`else
            check("blink_frame", 32'(is_blank), 32'h0);
`endif
            idle(FRAME);
        end
`ifdef SEG7_BLINK_EN
        check("blink_count", 32'(blank_cnt), 32'h4);
`else
        check("blink_count", 32'(blank_cnt), 32'h0);
`endif

        // Randomized traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(7) == 0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Reset mid-frame with a load pending: load is dropped.
        idle_until(3, FRAME);
        tick(1'b1, 16'hABCD, 4'hF, 4'h0, 4'h0);
        idle(2);
        apply_reset();
        upd_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            idle(1);
            upd_cnt += int'(updated);
            if (e % SCAN_DIV == 1) check("rst_zero_seg", 32'(seg), 32'h000000C0);
        end
        check("rst_no_upd", 32'(upd_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
